// File: rtl/clp_output_pool_pkg.sv
// Constants shared by the CLP output stage and the feature-memory controller.
// Holds the lane geometry, the CLP_type bit positions and a signed max helper.
package clp_output_pool_pkg;

  localparam int unsigned Tm            = 8;
  localparam int unsigned FEATURE_WIDTH = 32;
  localparam int unsigned CLP_RELU_BIT  = 0;
  localparam int unsigned CLP_POOL_BIT  = 1;

  typedef logic signed [FEATURE_WIDTH-1:0] feature_t;

  function automatic feature_t max_s(input feature_t a, input feature_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clp_output_pool_if.sv
// Input-pixel / output-beat bundle between the CLP accumulator, this stage and feature memory.
interface clp_output_pool_if;
  import clp_output_pool_pkg::*;

  logic                          state;
  logic [3:0]                    CLP_type;
  logic                          in_valid;
  logic [Tm*FEATURE_WIDTH-1:0]   in_data;
  logic                          CLP_output_flag;
  logic [Tm*FEATURE_WIDTH-1:0]   CLP_output;
  logic                          done;

  modport master (
    output state, CLP_type, in_valid, in_data,
    input  CLP_output_flag, CLP_output, done
  );

  modport slave (
    input  state, CLP_type, in_valid, in_data,
    output CLP_output_flag, CLP_output, done
  );

endinterface

// File: rtl/clp_output_pool_pool_row_buffer.sv
// Holds the horizontal 2-to-1 maxima of an even row until the odd row below reads them.
module pool_row_buffer #(
  parameter int unsigned Depth = 12,
  parameter int unsigned Width = 256,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [Aw-1:0]    i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [Aw-1:0]    i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read keeps the pooled result inside the single output register stage.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/clp_output_pool.sv
// CLP output stage: optional ReLU then optional 2x2/stride-2 max pool, one registered beat
// per result towards the feature-memory write port.
module clp_output_pool
  import clp_output_pool_pkg::*;
#(
  parameter int unsigned OUT_SIZE = 24
) (
  input logic              clk,
  input logic              rst,
  clp_output_pool_if.slave io_bus
);

  localparam int unsigned CntW     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned BufDepth = OUT_SIZE / 2;
  localparam int unsigned BufAw    = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned LastIdx  = OUT_SIZE - 1;
  localparam int unsigned PoolLast = (OUT_SIZE / 2) * 2 - 1;

  typedef logic [Tm-1:0][FEATURE_WIDTH-1:0] lanes_t;

  logic            r_state_q;
  logic            r_relu_en;
  logic            r_pool_en;
  logic [CntW-1:0] r_col;
  logic [CntW-1:0] r_row;
  lanes_t          r_h_reg;
  logic            r_flag;
  logic            r_done;
  lanes_t          r_out;

  logic            w_start;
  logic            w_relu;
  logic            w_pool;
  logic            w_accept;
  logic            w_last_px;
  logic            w_buf_we;
  logic [BufAw-1:0] w_buf_addr;
  lanes_t          w_px;
  lanes_t          w_hmax;
  lanes_t          w_buf_rdata;
  lanes_t          w_pooled;
  logic            w_emit;
  logic            w_emit_done;
  lanes_t          w_emit_data;
  logic [CntW-1:0] w_col_d;
  logic [CntW-1:0] w_row_d;
  logic            w_unused_type;

  // The beat that coincides with the rising edge of state already uses the new mode.
  assign w_start    = io_bus.state & ~r_state_q;
  assign w_relu     = w_start ? io_bus.CLP_type[CLP_RELU_BIT] : r_relu_en;
  assign w_pool     = w_start ? io_bus.CLP_type[CLP_POOL_BIT] : r_pool_en;
  assign w_accept   = io_bus.state & io_bus.in_valid;
  assign w_last_px  = (r_col == CntW'(LastIdx)) && (r_row == CntW'(LastIdx));
  assign w_buf_we   = w_accept & w_pool & ~r_row[0] & r_col[0];
  assign w_buf_addr = BufAw'(r_col >> 1);

  assign w_unused_type = ^io_bus.CLP_type[3:2];

  genvar g;
  generate
    for (g = 0; g < Tm; g++) begin : g_lane
      feature_t w_lane_in;
      assign w_lane_in   = feature_t'(io_bus.in_data[g*FEATURE_WIDTH +: FEATURE_WIDTH]);
      assign w_px[g]     = (w_relu && w_lane_in[FEATURE_WIDTH-1]) ? '0 : w_lane_in;
      assign w_hmax[g]   = max_s(r_h_reg[g], w_px[g]);
      assign w_pooled[g] = max_s(w_buf_rdata[g], w_hmax[g]);
    end
  endgenerate

  pool_row_buffer #(
    .Depth (BufDepth),
    .Width (Tm * FEATURE_WIDTH),
    .Aw    (BufAw)
  ) u_row_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (w_buf_addr),
    .i_wdata (w_hmax),
    .i_raddr (w_buf_addr),
    .o_rdata (w_buf_rdata)
  );

  // Odd OUT_SIZE: the trailing even column/row never reach the odd/odd emit point.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_done = 1'b0;
    w_emit_data = w_px;
    if (w_accept) begin
      if (w_pool) begin
        w_emit      = r_row[0] & r_col[0];
        w_emit_done = w_emit && (r_row == CntW'(PoolLast)) && (r_col == CntW'(PoolLast));
        w_emit_data = w_pooled;
      end else begin
        w_emit      = 1'b1;
        w_emit_done = w_last_px;
      end
    end
  end

  always_comb begin
    w_col_d = r_col;
    w_row_d = r_row;
    if (!io_bus.state) begin
      w_col_d = '0;
      w_row_d = '0;
    end else if (w_accept) begin
      if (r_col == CntW'(LastIdx)) begin
        w_col_d = '0;
        w_row_d = (r_row == CntW'(LastIdx)) ? '0 : r_row + 1'b1;
      end else begin
        w_col_d = r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= 1'b0;
      r_relu_en <= 1'b0;
      r_pool_en <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      r_state_q <= io_bus.state;
      r_col     <= w_col_d;
      r_row     <= w_row_d;
      if (w_start) begin
        r_relu_en <= w_relu;
        r_pool_en <= w_pool;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_reg <= '0;
    end else if (w_accept && w_pool && !r_col[0]) begin
      r_h_reg <= w_px;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
    end else begin
      r_flag <= w_emit;
      r_done <= w_emit_done;
      if (w_emit) begin
        r_out <= w_emit_data;
      end
    end
  end

  assign io_bus.CLP_output_flag = r_flag;
  assign io_bus.CLP_output      = r_out;
  assign io_bus.done            = r_done;

endmodule

// File: tb/tb_clp_output_pool.sv
// Randomised bench for clp_output_pool (OUT_SIZE=4) against a window-level reference model.
module tb_clp_output_pool;
  import clp_output_pool_pkg::*;

  localparam int N     = 4;
  localparam int W     = FEATURE_WIDTH;
  localparam int DataW = Tm * FEATURE_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clp_output_pool_if bus ();

  clp_output_pool #(
    .OUT_SIZE (N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [DataW-1:0] got,
                       input logic [DataW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: keeps the whole map and pools each 2x2 window directly.
  int               img [N][N][Tm];
  bit               m_relu, m_pool, m_prev;
  int               m_col, m_row;
  logic             exp_flag, exp_done;
  logic [DataW-1:0] exp_data;

  always @(posedge clk) begin
    if (rst) begin
      m_relu = 0; m_pool = 0; m_prev = 0; m_col = 0; m_row = 0;
      exp_flag = 0; exp_done = 0; exp_data = '0;
    end else begin
      exp_flag = 0;
      exp_done = 0;
      if (bus.state && !m_prev) begin
        m_relu = bus.CLP_type[0];
        m_pool = bus.CLP_type[1];
      end
      m_prev = bus.state;
      if (!bus.state) begin
        m_col = 0;
        m_row = 0;
      end else if (bus.in_valid) begin
        for (int l = 0; l < Tm; l++) begin
          int v;
          v = int'($signed(bus.in_data[l*W +: W]));
          if (m_relu && v < 0) v = 0;
          img[m_row][m_col][l] = v;
        end
        if (!m_pool) begin
          exp_flag = 1;
          for (int l = 0; l < Tm; l++) exp_data[l*W +: W] = img[m_row][m_col][l];
          exp_done = (m_row == N - 1) && (m_col == N - 1);
        end else if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
          exp_flag = 1;
          for (int l = 0; l < Tm; l++) begin
            int mx;
            mx = img[m_row][m_col][l];
            if (img[m_row-1][m_col-1][l] > mx) mx = img[m_row-1][m_col-1][l];
            if (img[m_row-1][m_col][l] > mx)   mx = img[m_row-1][m_col][l];
            if (img[m_row][m_col-1][l] > mx)   mx = img[m_row][m_col-1][l];
            exp_data[l*W +: W] = mx;
          end
          exp_done = (m_row / 2 == N / 2 - 1) && (m_col / 2 == N / 2 - 1);
        end
        m_col++;
        if (m_col == N) begin
          m_col = 0;
          m_row++;
          if (m_row == N) m_row = 0;
        end
      end
    end
  end

  int obs0 [$];
  int obs3 [$];
  int done_vals [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("flag", DataW'(bus.CLP_output_flag), DataW'(exp_flag));
      check("data", bus.CLP_output, exp_data);
      check("done", DataW'(bus.done), DataW'(exp_done));
      if (bus.CLP_output_flag) begin
        obs0.push_back(int'($signed(bus.CLP_output[W-1:0])));
        obs3.push_back(int'($signed(bus.CLP_output[3*W +: W])));
      end
      if (bus.done) done_vals.push_back(int'($signed(bus.CLP_output[W-1:0])));
    end
  end

  task automatic clear_obs();
    obs0.delete();
    obs3.delete();
    done_vals.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = {Tm{32'($urandom)}};
    end
  endtask

  task automatic start_layer(input logic [3:0] t);
    @(negedge clk);
    bus.state    = 1'b1;
    bus.CLP_type = t;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.CLP_type = 4'($urandom);
  endtask

  task automatic stop_layer();
    @(negedge clk);
    bus.state    = 1'b0;
    bus.in_valid = 1'b0;
    idle(2);
  endtask

  task automatic pix(input int v, input int v3, input int gap);
    idle(gap);
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int l = 0; l < Tm; l++) bus.in_data[l*W +: W] = (l == 3) ? v3 : v;
  endtask

  task automatic pix_rand(input int gap);
    idle(gap);
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int l = 0; l < Tm; l++) begin
      if ($urandom_range(0, 3) == 0) bus.in_data[l*W +: W] = $urandom;
      else bus.in_data[l*W +: W] = int'($urandom_range(0, 200)) - 100;
    end
  endtask

  task automatic check_list(input string tag, input int got [$], input int exp [$]);
    check({tag, "_count"}, DataW'(got.size()), DataW'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_%0d", tag, i), DataW'(got[i]), DataW'(exp[i]));
  endtask

  initial begin
    int exp_q [$];
    int a [16];
    int b [16];

    rst = 1'b1;
    bus.state = 1'b0;
    bus.CLP_type = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(negedge clk);
    check("reset_flag", DataW'(bus.CLP_output_flag), '0);
    check("reset_data", bus.CLP_output, '0);
    check("reset_done", DataW'(bus.done), '0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Pass-through, -3..12.
    clear_obs();
    start_layer(4'd0);
    for (int i = 0; i < 16; i++) pix(i - 3, i - 3, 0);
    stop_layer();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(i - 3);
    check_list("s1", obs0, exp_q);
    check_list("s1_done", done_vals, '{12});

    // ReLU only.
    clear_obs();
    start_layer(4'd1);
    pix(-5, -5, 0); pix(7, 7, 0); pix(-1, -1, 0); pix(0, 0, 0);
    for (int i = 4; i < 16; i++) pix_rand(0);
    stop_layer();
    check("s2_count", DataW'(obs0.size()), DataW'(16));
    check_list("s2_head", obs0[0:3], '{0, 7, 0, 0});

    // Pool.
    clear_obs();
    start_layer(4'd2);
    for (int i = 0; i < 16; i++) pix(i, i, 0);
    stop_layer();
    check_list("s3", obs0, '{5, 7, 13, 15});
    check_list("s3_done", done_vals, '{15});

    // Signed pool with and without ReLU; lane 3 independent.
    for (int t = 2; t <= 3; t++) begin
      for (int i = 0; i < 16; i++) begin
        a[i] = int'($urandom_range(0, 40)) - 20;
        b[i] = int'($urandom_range(0, 40)) - 20;
      end
      a[0] = -8; a[1] = -2; a[4] = -5; a[5] = -9;
      b[0] = 100; b[1] = -1; b[4] = 3; b[5] = 2;
      clear_obs();
      start_layer(4'(t));
      for (int i = 0; i < 16; i++) pix(a[i], b[i], 0);
      stop_layer();
      check($sformatf("s4_t%0d_count", t), DataW'(obs0.size()), DataW'(4));
      check($sformatf("s4_t%0d_lane0", t), DataW'(obs0[0]), DataW'((t == 2) ? -2 : 0));
      check($sformatf("s4_t%0d_lane3", t), DataW'(obs3[0]), DataW'(100));
    end

    // Bubbles across two consecutive maps.
    clear_obs();
    start_layer(4'd2);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++) pix(i, i, $urandom_range(0, 2));
    stop_layer();
    check_list("s5", obs0, '{5, 7, 13, 15, 5, 7, 13, 15});
    check_list("s5_done", done_vals, '{15, 15});

    // Abort: state falls together with the sixth pixel, then pass-through from (0,0).
    clear_obs();
    start_layer(4'd2);
    for (int i = 0; i < 5; i++) pix(i, i, 0);
    @(negedge clk);
    bus.state = 1'b0;
    bus.in_valid = 1'b1;
    idle(3);
    check("s6_abort_count", DataW'(obs0.size()), '0);
    start_layer(4'd0);
    for (int i = 0; i < 16; i++) pix(100 + i, 100 + i, 0);
    stop_layer();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(100 + i);
    check_list("s6", obs0, exp_q);

    // Asynchronous reset mid-map.
    start_layer(4'd0);
    for (int i = 0; i < 5; i++) pix(i + 1, i + 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    bus.state = 1'b0;
    #1;
    check("rst_flag_now", DataW'(bus.CLP_output_flag), '0);
    check("rst_data_now", bus.CLP_output, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(3);
    clear_obs();
    start_layer(4'd0);
    for (int i = 0; i < 16; i++) pix(i, i, 0);
    stop_layer();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    check_list("s6_rst", obs0, exp_q);

    // Random modes, data and bubbles.
    for (int k = 0; k < 8; k++) begin
      start_layer(4'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 2))
        for (int i = 0; i < 16; i++) pix_rand($urandom_range(0, 2));
      stop_layer();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
